traffic_phase_timer: RTL and testbench
======================================

# traffic_phase_timer

Phase sequencer for the traffic-light datapath, sitting directly downstream of the phase-duration register file. It drives that register file's read port A (read enable and read address), takes back the registered 3-bit duration, and counts it down on external tick pulses. It drives the one-hot red/yellow/green lamp outputs and cycles GREEN → YELLOW → RED (→ ALL-RED) → GREEN.

## Interface
- `data_width`, 3: duration word width; must match the register file's data width.
- `reg_width`, 2: register address width; must match the register file's address width.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `en` in 1: run enable; low forces IDLE.
- `tick` in 1: one-cycle time-base pulse; each pulse consumes one duration unit.
- `dur_in` in `data_width`: duration from the register file's port A output.
- `RE` out 1: read enable to the register file's port A.
- `RA` out `reg_width`: read address to the register file's port A.
- `green`, `yellow`, `red` out 1 each: lamp outputs, exactly one high at all times.
- `remaining` out `data_width`: current countdown value.
- `phase_done` out 1: one-cycle pulse when a phase expires.

## Operation
- Phase-to-address map: GREEN=0, YELLOW=1, RED=2, ALL-RED=3.
- FSM states:
  - IDLE
    - Lamps: red only.
    - `RE`=0.
    - Phase pointer is forced to GREEN.
    - If `en`=1, go to FETCH.
  - FETCH
    - `RE`=1 and `RA`=phase address for exactly this cycle.
    - Always go to WAIT.
  - WAIT
    - `dur_in` is valid this cycle, because the register file output is registered.
    - `remaining` loads `dur_in`. A duration of 0 loads 1: the minimum phase length is one tick.
    - Always go to RUN.
  - RUN, on `tick`=1:
    - If `remaining`=1: pulse `phase_done`, advance the phase pointer, go to FETCH.
    - Otherwise: decrement `remaining`.
  - RUN, on `tick`=0: hold.
- Lamp outputs decode the phase pointer in FETCH, WAIT and RUN. They therefore change on the same edge that enters FETCH of the next phase, and stay stable through the fetch.
- ALL-RED phase lamps: red only.
- `tick` is ignored in IDLE, FETCH and WAIT; the fetch overhead is not charged to the phase.
- `en`=0 in any state:
  - Next state is IDLE.
  - Takes priority over `tick` and over phase expiry in the same cycle.
  - No `phase_done` pulse.
  - `remaining` clears to 0.
- Phase pointer advance: RED → GREEN, or RED → ALL-RED → GREEN when the ALL-RED phase is configured in. No other transitions.
- `remaining` never underflows; the decrement happens only when `remaining` > 1.

## Timing
- Reset values (`RST_N`=0 at a rising edge):
  - state IDLE, phase GREEN;
  - `red`=1, `green`=0, `yellow`=0;
  - `RE`=0, `RA`=0;
  - `remaining`=0, `phase_done`=0.
- Reset has priority over `en` and `tick`. Reset mid-phase gives IDLE on the next edge with the values above.
- All outputs are registered.
- Latency:
  - `en` rise to `RE` high: 1 cycle (IDLE→FETCH).
  - `RE` high to `remaining` loaded: 2 edges.
  - First decrement is possible in the first RUN cycle.
- Phase length: max(d,1) ticks, plus 2 clock cycles of fetch overhead.
- `phase_done` is high in the FETCH cycle of the next phase, for 1 cycle.
- `RE` is never high for two consecutive cycles.

## Configuration
- `ALL_RED_EN` defined:
  - RED advances to ALL-RED.
  - ALL-RED reads address 3 and shows red only, then advances to GREEN.
- `ALL_RED_EN` undefined:
  - RED advances to GREEN directly.
  - Address 3 is never issued on `RA`.

## Test plan
- Reset check: assert `RST_N`=0 with `en`=1 and `tick`=1 → next cycle `red`=1, `RE`=0, `remaining`=0, `phase_done`=0.
- Nominal cycle: regfile {G=3, Y=1, R=2, A=1}, `tick` every cycle, `en`=1 → `RA` sequence 0,1,2,0 (macro off) or 0,1,2,3,0 (macro on). Green lasts 3+2 cycles; `phase_done` pulses once per phase.
- Zero duration: Y=0 → yellow lasts exactly 1 tick plus 2 cycles; no underflow; `remaining` never exceeds 1 in that phase.
- Sparse tick: G=2, `tick` every 4th cycle, plus ticks injected during FETCH/WAIT → injected ticks are ignored; green ends after exactly 2 RUN ticks.
- Abort: `en`=0 in the same cycle as the expiring tick of GREEN → IDLE, red only, no `phase_done`. Re-enable → restarts at GREEN with `RA`=0.
- Reset mid-RUN with `remaining`=2 → next cycle IDLE, `remaining`=0, `red`=1.

Source files
------------

// File: rtl/traffic_phase_timer_if.sv
// Register-file read port A as seen by traffic_phase_timer: read enable and address out, registered duration back.
interface traffic_phase_timer_if #(
  parameter int data_width = 3,
  parameter int reg_width  = 2
);
  logic                  RE;
  logic [reg_width-1:0]  RA;
  logic [data_width-1:0] dur_in;

  modport master (output RE, RA, input dur_in);
  modport slave  (input RE, RA, output dur_in);
endinterface

// File: rtl/traffic_phase_timer.sv
// Traffic-light phase sequencer: fetches each phase duration from the register file and counts it down on ticks.
// Optional ALL-RED phase after RED is enabled by defining ALL_RED_EN.
module traffic_phase_timer #(
  parameter int data_width = 3,
  parameter int reg_width  = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   en,
  input  logic                   tick,
  traffic_phase_timer_if.master  bus,
  output logic                   green,
  output logic                   yellow,
  output logic                   red,
  output logic [data_width-1:0]  remaining,
  output logic                   phase_done
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RUN} state_t;
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2,
    PH_ALLRED = 2'd3
  } phase_t;

  state_t                state, state_nxt;
  phase_t                phase, phase_nxt;
  logic [data_width-1:0] rem_nxt;
  logic [data_width-1:0] load_val;
  logic                  done_nxt;
  logic                  green_nxt, yellow_nxt, red_nxt;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
`ifdef ALL_RED_EN
      PH_RED:    next_phase = PH_ALLRED;
`else
      PH_RED:    next_phase = PH_GREEN;
`endif
      default:   next_phase = PH_GREEN;
    endcase
  endfunction

  // A zero duration still lasts one tick.
  assign load_val = (bus.dur_in == '0) ? data_width'(1) : bus.dur_in;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    rem_nxt   = remaining;
    done_nxt  = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      phase_nxt = PH_GREEN;
      rem_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = FETCH;
          phase_nxt = PH_GREEN;
        end
        FETCH: state_nxt = WAIT;
        WAIT: begin
          state_nxt = RUN;
          rem_nxt   = load_val;
        end
        RUN: begin
          if (tick) begin
            if (remaining == data_width'(1)) begin
              done_nxt  = 1'b1;
              phase_nxt = next_phase(phase);
              state_nxt = FETCH;
            end else if (remaining > data_width'(1)) begin
              rem_nxt = remaining - data_width'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Lamps are registered from the next phase so they switch on the edge entering FETCH.
  always_comb begin
    green_nxt  = 1'b0;
    yellow_nxt = 1'b0;
    red_nxt    = 1'b0;
    if (state_nxt == IDLE) begin
      red_nxt = 1'b1;
    end else begin
      case (phase_nxt)
        PH_GREEN:  green_nxt  = 1'b1;
        PH_YELLOW: yellow_nxt = 1'b1;
        default:   red_nxt    = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      phase      <= PH_GREEN;
      bus.RE     <= 1'b0;
      bus.RA     <= '0;
      green      <= 1'b0;
      yellow     <= 1'b0;
      red        <= 1'b1;
      remaining  <= '0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      bus.RE     <= (state_nxt == FETCH);
      if (state_nxt == FETCH) bus.RA <= reg_width'(phase_nxt);
      green      <= green_nxt;
      yellow     <= yellow_nxt;
      red        <= red_nxt;
      remaining  <= rem_nxt;
      phase_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer: directed table, corner sequences and randomized runs vs a phase-timeline model.
module tb_traffic_phase_timer;

  logic       CLK;
  logic       RST_N;
  logic       en;
  logic       tick;
  logic       green, yellow, red, phase_done;
  logic [2:0] remaining;
  int         n_cmp;
  int         n_bad;
  int         regs [4];

  traffic_phase_timer_if #(.data_width(3), .reg_width(2)) bus ();

  traffic_phase_timer #(.data_width(3), .reg_width(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .tick(tick), .bus(bus),
    .green(green), .yellow(yellow), .red(red),
    .remaining(remaining), .phase_done(phase_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file with registered port A output.
  always @(posedge CLK) begin
    if (bus.RE === 1'b1) bus.dur_in <= 3'(regs[bus.RA]);
  end

  // Model: where we are in the phase timeline (age 0 = fetch, 1 = wait, 2 = counting) and ticks used.
  int m_active, m_phase, m_age, m_len, m_used, m_rem, m_done;

  function automatic int nxt_phase(input int p);
`ifdef ALL_RED_EN
    return (p + 1) % 4;
`else
    return (p >= 2) ? 0 : p + 1;
`endif
  endfunction

  task automatic model_update(input logic r, input logic e, input logic t);
    if (!r || !e) begin
      m_active = 0; m_phase = 0; m_age = 0; m_rem = 0; m_done = 0;
    end else if (m_active == 0) begin
      m_active = 1; m_age = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_age == 0) m_age = 1;
      else if (m_age == 1) begin
        m_len  = (regs[m_phase] == 0) ? 1 : regs[m_phase];
        m_used = 0;
        m_rem  = m_len;
        m_age  = 2;
      end else if (t) begin
        m_used++;
        if (m_used == m_len) begin
          m_done  = 1;
          m_phase = nxt_phase(m_phase);
          m_age   = 0;
        end else m_rem = m_len - m_used;
      end
    end
  endtask

  // Output vector layout: {RE, RA[1:0] (zero unless RE), green, yellow, red, remaining[2:0], phase_done}
  function automatic logic [9:0] ev(input logic re, input logic [1:0] ra, input logic g,
                                    input logic y, input logic rd, input logic [2:0] rem, input logic d);
    return {re, re ? ra : 2'b00, g, y, rd, rem, d};
  endfunction

  function automatic logic [9:0] model_vec();
    logic re, g, y, rd;
    re = (m_active != 0) && (m_age == 0);
    g = 1'b0; y = 1'b0; rd = 1'b0;
    if (m_active == 0) rd = 1'b1;
    else if (m_phase == 0) g = 1'b1;
    else if (m_phase == 1) y = 1'b1;
    else rd = 1'b1;
    return ev(re, 2'(m_phase), g, y, rd, 3'(m_rem), m_done[0]);
  endfunction

  function automatic logic [9:0] act_vec();
    return ev(bus.RE, bus.RA, green, yellow, red, remaining, phase_done);
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic t);
    @(negedge CLK);
    RST_N = r; en = e; tick = t;
    @(posedge CLK);
    model_update(r, e, t);
    #1;
  endtask

  task automatic mstep(input string name, input logic r, input logic e, input logic t);
    step(r, e, t);
    check(name, act_vec(), model_vec());
  endtask

  typedef struct {
    logic       r, e, t;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int cnt, maxrem, guard;
    n_cmp = 0; n_bad = 0;
    RST_N = 1'b0; en = 1'b0; tick = 1'b0;
    bus.dur_in = '0;
    m_active = 0; m_phase = 0; m_age = 0; m_len = 0; m_used = 0; m_rem = 0; m_done = 0;

    // Nominal cycle, regfile {G=3, Y=1, R=2, A=1}, tick every cycle.
    regs = '{3, 1, 2, 1};
    tbl[0]  = '{1'b0, 1'b1, 1'b1, ev(0, 0, 0, 0, 1, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, ev(1, 0, 1, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, ev(0, 0, 1, 0, 0, 0, 0)};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, ev(0, 0, 1, 0, 0, 3, 0)};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, ev(0, 0, 1, 0, 0, 2, 0)};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, ev(0, 0, 1, 0, 0, 1, 0)};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, ev(1, 1, 0, 1, 0, 1, 1)};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, ev(0, 0, 0, 1, 0, 1, 0)};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, ev(0, 0, 0, 1, 0, 1, 0)};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, ev(1, 2, 0, 0, 1, 1, 1)};
    tbl[10] = '{1'b1, 1'b1, 1'b1, ev(0, 0, 0, 0, 1, 1, 0)};
    tbl[11] = '{1'b1, 1'b1, 1'b1, ev(0, 0, 0, 0, 1, 2, 0)};
    tbl[12] = '{1'b1, 1'b1, 1'b1, ev(0, 0, 0, 0, 1, 1, 0)};
`ifdef ALL_RED_EN
    tbl[13] = '{1'b1, 1'b1, 1'b1, ev(1, 3, 0, 0, 1, 1, 1)};
`else
    tbl[13] = '{1'b1, 1'b1, 1'b1, ev(1, 0, 1, 0, 0, 1, 1)};
`endif
    tbl[14] = '{1'b1, 1'b0, 1'b1, ev(0, 0, 0, 0, 1, 0, 0)};
    tbl[15] = '{1'b1, 1'b1, 1'b0, ev(1, 0, 1, 0, 0, 0, 0)};
    tbl[16] = '{1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0, 0)};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].t);
      check($sformatf("table_row%0d", i), act_vec(), tbl[i].exp);
      if (i == 0) check_int("reset_ra", int'(bus.RA), 0);
    end

    // Zero-length yellow: exactly one tick plus two fetch cycles, remaining never above 1.
    regs = '{2, 0, 3, 1};
    mstep("zero_reset", 1'b0, 1'b0, 1'b0);
    cnt = 0; maxrem = 0; guard = 0;
    do begin
      mstep("zero_run", 1'b1, 1'b1, 1'b1);
      if (yellow) begin
        cnt++;
        if (int'(remaining) > maxrem) maxrem = int'(remaining);
      end
      guard++;
    end while (!(red && bus.RE) && guard < 50);
    check_int("zero_found_red", int'(guard < 50), 1);
    check_int("zero_yellow_cycles", cnt, 3);
    check_int("zero_yellow_maxrem", maxrem, 1);

    // Sparse tick with ticks injected during IDLE/FETCH/WAIT.
    regs = '{2, 1, 1, 1};
    mstep("sparse_reset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++)
      mstep("sparse_run", 1'b1, 1'b1, (i % 4 == 3) || (i < 3));

    // Abort on the expiring green tick, then re-enable.
    regs = '{2, 1, 1, 1};
    mstep("abort_reset", 1'b0, 1'b0, 1'b0);
    mstep("abort_fetch", 1'b1, 1'b1, 1'b0);
    mstep("abort_wait",  1'b1, 1'b1, 1'b0);
    mstep("abort_load",  1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("abort_rem1", act_vec(), ev(0, 0, 1, 0, 0, 1, 0));
    step(1'b1, 1'b0, 1'b1);
    check("abort_idle", act_vec(), ev(0, 0, 0, 0, 1, 0, 0));
    step(1'b1, 1'b1, 1'b1);
    check("abort_restart", act_vec(), ev(1, 0, 1, 0, 0, 0, 0));

    // Reset while counting with remaining=2.
    regs = '{3, 1, 1, 1};
    mstep("rst_mid_reset", 1'b0, 1'b0, 1'b0);
    mstep("rst_mid_fetch", 1'b1, 1'b1, 1'b0);
    mstep("rst_mid_wait",  1'b1, 1'b1, 1'b0);
    mstep("rst_mid_load",  1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("rst_mid_rem2", act_vec(), ev(0, 0, 1, 0, 0, 2, 0));
    step(1'b0, 1'b1, 1'b1);
    check("rst_mid_idle", act_vec(), ev(0, 0, 0, 0, 1, 0, 0));
    check_int("rst_mid_ra", int'(bus.RA), 0);

    // Randomized segments against the model.
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) regs[k] = $urandom_range(0, 7);
      mstep("rand_reset", 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) begin
        mstep($sformatf("rand_s%0d_c%0d", s, i),
              ($urandom_range(0, 199) != 0),
              ($urandom_range(0, 24) != 0),
              (s[0] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
